rpn_lan_rx_seq_checker: RTL

Receive-side reliability stage for the RPN LAN path, directly downstream of the LAN-from-network-bridge splitter's RX output. It consumes LAN_PUB and LAN_SEQ_NUM_CHECK packets and keeps a per-sender expected-sequence-number table. In-order PUB packets pass to the application; duplicates and out-of-order PUBs are dropped. A single-beat LAN_ACK or LAN_SEQ_NUM_REPLY goes back toward the network bridge.

---
 rtl/rpn_lan_rx_seq_checker.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/rpn_lan_rx_seq_checker.sv
// Receive-side sequence checker: forwards in-order LAN_PUB packets, drops duplicates and
// out-of-order traffic, and answers with single-beat ACK / SEQ_NUM_REPLY responses.
module rpn_lan_rx_seq_checker #(
  parameter int AXIS_DATA_WIDTH    = 64,
  parameter int AXIS_KEEP_WIDTH    = 8,
  parameter int AXIS_TDEST_WIDTH   = 8,
  parameter int AXIS_TUSER_WIDTH   = 32,
  parameter int RPN_MSG_TYPE_WIDTH = 8,
  parameter int NODE_ID_OFFSET     = 8,
  parameter int NODE_ID_WIDTH      = 8,
  parameter int SEQ_NUM_OFFSET     = 16,
  parameter int SEQ_NUM_WIDTH      = 16,
  parameter int NUM_NODES          = 16,
  parameter logic [RPN_MSG_TYPE_WIDTH-1:0] MSG_LAN_PUB           = 'h10,
  parameter logic [RPN_MSG_TYPE_WIDTH-1:0] MSG_LAN_SEQ_NUM_CHECK = 'h11,
  parameter logic [RPN_MSG_TYPE_WIDTH-1:0] MSG_LAN_SEQ_NUM_REPLY = 'h12,
  parameter logic [RPN_MSG_TYPE_WIDTH-1:0] MSG_LAN_ACK           = 'h13
) (
  input  logic                        i_clk,
  input  logic                        i_rst,

  input  logic                        from_splitter_tvalid,
  output logic                        from_splitter_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_splitter_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_splitter_tkeep,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_splitter_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0] from_splitter_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] from_splitter_tuser,
  input  logic                        from_splitter_tlast,

  output logic                        to_app_tvalid,
  input  logic                        to_app_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  to_app_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  to_app_tkeep,
  output logic [AXIS_TDEST_WIDTH-1:0] to_app_tid,
  output logic [AXIS_TDEST_WIDTH-1:0] to_app_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0] to_app_tuser,
  output logic                        to_app_tlast,

  output logic                        to_resp_tvalid,
  input  logic                        to_resp_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  to_resp_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  to_resp_tkeep,
  output logic [AXIS_TDEST_WIDTH-1:0] to_resp_tid,
  output logic [AXIS_TDEST_WIDTH-1:0] to_resp_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0] to_resp_tuser,
  output logic                        to_resp_tlast,

  output logic [15:0]                 o_drop_count,
  output logic [1:0]                  o_dbg_state
);

  // All three streams use AXI-Stream valid/ready: a beat moves on a cycle where both
  // tvalid and tready are high; a source never drops tvalid or changes data while stalled.

  localparam int IDX_W = $clog2(NUM_NODES);
  localparam logic [NODE_ID_WIDTH:0]   NUM_NODES_W = (NODE_ID_WIDTH+1)'(NUM_NODES);
  localparam logic [SEQ_NUM_WIDTH-1:0] SEQ_ONE     = SEQ_NUM_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_SINK = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SEQ_NUM_WIDTH-1:0]      table_q [NUM_NODES];
  logic [SEQ_NUM_WIDTH-1:0]      table_d [NUM_NODES];
  logic [15:0]                   drop_q, drop_d;

  logic                          resp_valid_q, resp_valid_d;
  logic [RPN_MSG_TYPE_WIDTH-1:0] resp_type_q, resp_type_d;
  logic [SEQ_NUM_WIDTH-1:0]      resp_seq_q, resp_seq_d;
  logic [AXIS_TDEST_WIDTH-1:0]   resp_own_q, resp_own_d;
  logic [NODE_ID_WIDTH-1:0]      resp_dst_q, resp_dst_d;

  logic [RPN_MSG_TYPE_WIDTH-1:0] hdr_type;
  logic [NODE_ID_WIDTH-1:0]      hdr_node;
  logic [SEQ_NUM_WIDTH-1:0]      hdr_seq;
  logic [IDX_W-1:0]              hdr_idx;
  logic [SEQ_NUM_WIDTH-1:0]      exp_seq;
  logic                          node_valid;
  logic                          is_fwd, is_dup, is_chk, is_drop;
  logic                          resp_full;
  logic                          hdr_ready;
  logic                          app_pass;
  logic                          from_hs;

  // Header decode is only meaningful in IDLE, where beat 0 is presented.
  assign hdr_type   = from_splitter_tdata[RPN_MSG_TYPE_WIDTH-1:0];
  assign hdr_node   = from_splitter_tdata[NODE_ID_OFFSET +: NODE_ID_WIDTH];
  assign hdr_seq    = from_splitter_tdata[SEQ_NUM_OFFSET +: SEQ_NUM_WIDTH];
  assign hdr_idx    = hdr_node[IDX_W-1:0];
  assign node_valid = ({1'b0, hdr_node} < NUM_NODES_W);
  assign exp_seq    = table_q[hdr_idx];

  assign is_fwd  = (hdr_type == MSG_LAN_PUB) && node_valid && (hdr_seq == exp_seq);
  assign is_dup  = (hdr_type == MSG_LAN_PUB) && node_valid && (hdr_seq == (exp_seq - SEQ_ONE));
  assign is_chk  = (hdr_type == MSG_LAN_SEQ_NUM_CHECK) && node_valid;
  assign is_drop = !is_fwd && !is_dup && !is_chk;

  // A slot being drained this cycle counts as free, so single-beat packets stream at full rate.
  assign resp_full = resp_valid_q && !to_resp_tready;

  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    drop_d       = drop_q;
    resp_valid_d = resp_valid_q;
    resp_type_d  = resp_type_q;
    resp_seq_d   = resp_seq_q;
    resp_own_d   = resp_own_q;
    resp_dst_d   = resp_dst_q;
    hdr_ready    = 1'b0;
    app_pass     = 1'b0;
    from_hs      = 1'b0;

    if (resp_valid_q && to_resp_tready) begin
      resp_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        hdr_ready = !resp_full && (is_fwd ? to_app_tready : 1'b1);
        app_pass  = is_fwd && !resp_full;
        from_hs   = from_splitter_tvalid && hdr_ready;
        if (from_hs) begin
          if (is_fwd || is_dup || is_chk) begin
            resp_valid_d = 1'b1;
            resp_type_d  = is_chk ? MSG_LAN_SEQ_NUM_REPLY : MSG_LAN_ACK;
            resp_seq_d   = is_chk ? exp_seq : hdr_seq;
            resp_own_d   = from_splitter_tdest;
            resp_dst_d   = hdr_node;
          end
          if (is_fwd) begin
            table_d[hdr_idx] = exp_seq + SEQ_ONE;
          end
          if ((is_dup || is_drop) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
          end
          if (!from_splitter_tlast) begin
            state_d = is_fwd ? ST_FWD : ST_SINK;
          end
        end
      end
      ST_FWD: begin
        hdr_ready = to_app_tready;
        app_pass  = 1'b1;
        from_hs   = from_splitter_tvalid && hdr_ready;
        if (from_hs && from_splitter_tlast) begin
          state_d = ST_IDLE;
        end
      end
      ST_SINK: begin
        hdr_ready = 1'b1;
        from_hs   = from_splitter_tvalid;
        if (from_hs && from_splitter_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are forced quiet for the whole reset cycle, not just after it.
    if (i_rst) begin
      hdr_ready = 1'b0;
      app_pass  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      drop_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_type_q  <= '0;
      resp_seq_q   <= '0;
      resp_own_q   <= '0;
      resp_dst_q   <= '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      resp_valid_q <= resp_valid_d;
      resp_type_q  <= resp_type_d;
      resp_seq_q   <= resp_seq_d;
      resp_own_q   <= resp_own_d;
      resp_dst_q   <= resp_dst_d;
      table_q      <= table_d;
    end
  end

  assign from_splitter_tready = hdr_ready;

  assign to_app_tvalid = from_splitter_tvalid && app_pass;
  assign to_app_tdata  = app_pass ? from_splitter_tdata : '0;
  assign to_app_tkeep  = app_pass ? from_splitter_tkeep : '0;
  assign to_app_tid    = app_pass ? from_splitter_tid   : '0;
  assign to_app_tdest  = app_pass ? from_splitter_tdest : '0;
  assign to_app_tuser  = app_pass ? from_splitter_tuser : '0;
  assign to_app_tlast  = app_pass && from_splitter_tlast;

  always_comb begin
    to_resp_tdata = '0;
    to_resp_tdata[RPN_MSG_TYPE_WIDTH-1:0]          = resp_type_q;
    to_resp_tdata[NODE_ID_OFFSET +: NODE_ID_WIDTH] = NODE_ID_WIDTH'(resp_own_q);
    to_resp_tdata[SEQ_NUM_OFFSET +: SEQ_NUM_WIDTH] = resp_seq_q;
  end

  assign to_resp_tvalid = resp_valid_q;
  assign to_resp_tkeep  = resp_valid_q ? AXIS_KEEP_WIDTH'('h0F) : '0;
  assign to_resp_tid    = resp_own_q;
  assign to_resp_tdest  = AXIS_TDEST_WIDTH'(resp_dst_q);
  assign to_resp_tuser  = '0;
  assign to_resp_tlast  = resp_valid_q;

  assign o_drop_count = drop_q;
  assign o_dbg_state  = state_q;

endmodule
